// File: rtl/router_rx_pkg.sv
// -----------------------------------------------------------------------------
// router_rx_pkg
// Shared definitions for the router channel receive sink.
//   - rx_state_e : parser FSM states (HDR -> [PAY] -> PAR)
//   - LEN_W / ADDR_W : header field widths
//   - header field slice positions and helpers to extract them
// Header byte layout: {len[5:0], addr[1:0]}
// -----------------------------------------------------------------------------
package router_rx_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  // Header field positions inside the first byte of a packet
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    PAR = 2'd2
  } rx_state_e;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] b);
    return b[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] b);
    return b[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

endpackage

// File: rtl/router_rx_sink_sat_cnt.sv
// -----------------------------------------------------------------------------
// router_rx_sat_cnt
// Saturating up-counter: increments by one on each cycle with i_inc high and
// sticks at all-ones instead of wrapping.
// Ports:
//   i_clk   in  1      clock, rising edge
//   i_rst_n in  1      asynchronous active-low reset (clears the count)
//   i_inc   in  1      increment enable
//   o_cnt   out CNT_W  current count
// -----------------------------------------------------------------------------
module router_rx_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/router_rx_sink.sv
// -----------------------------------------------------------------------------
// router_rx_sink
// Consumer for one output channel of the 1x3 router. Pulls bytes out of the
// router FIFO, parses {header, len payload bytes, parity byte}, checks parity
// and destination address, and forwards every byte with sop/eop framing to a
// local sink.
//
// Build option: define RX_STATS_EN to get live saturating pkt_cnt / err_cnt.
// Without it both counter ports are tied to zero.
//
// Ports:
//   clk         in  1      clock, rising edge
//   resetn      in  1      asynchronous active-low reset
//   vld_out     in  1      router channel FIFO non-empty
//   data_out    in  8      router read data, valid the cycle after read_enb
//   sink_ready  in  1      local sink can accept a byte
//   read_enb    out 1      FIFO read strobe to the router
//   byte_data   out 8      forwarded byte
//   byte_valid  out 1      byte_data valid
//   byte_sop    out 1      forwarded byte is the header
//   byte_eop    out 1      forwarded byte is the parity byte
//   pkt_done    out 1      one-cycle pulse after the parity byte
//   pkt_len     out 6      payload length of the last completed packet
//   parity_err  out 1      last packet had a parity mismatch
//   addr_err    out 1      last packet addr field != CHANNEL
//   pkt_cnt     out CNT_W  completed packets (RX_STATS_EN)
//   err_cnt     out CNT_W  packets with any error (RX_STATS_EN)
//   dbg_state   out 2      parser FSM state, for observation only
//
// Handshake: the router side is a read strobe -- read_enb is only raised when
// vld_out says the FIFO has data, and data_out carries that byte one cycle
// later. The sink side is valid/ready-like with one cycle of slack: read_enb
// is gated by sink_ready, so once sink_ready drops no new read is issued, but
// the byte already requested still appears (byte_valid=1) on the next cycle
// and the sink must take it. byte_valid is never withheld or repeated.
// -----------------------------------------------------------------------------
module router_rx_sink
  import router_rx_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CHANNEL = 2'd0,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic [BYTE_W-1:0] data_out,
  input  logic              sink_ready,
  output logic              read_enb,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              byte_sop,
  output logic              byte_eop,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              parity_err,
  output logic              addr_err,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        dbg_state
);

  // ---------------------------------------------------------------------------
  // Parser state
  // ---------------------------------------------------------------------------
  rx_state_e         r_state;
  logic              r_cap_v;    // a byte read last cycle is on data_out now
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_rem;      // payload bytes still to come
  logic [ADDR_W-1:0] r_addr;
  logic [BYTE_W-1:0] r_par_acc;  // running XOR of header + payload

  // Completion registers
  logic              r_pkt_done;
  logic [LEN_W-1:0]  r_pkt_len;
  logic              r_parity_err;
  logic              r_addr_err;

  logic              w_par_cap;
  logic              w_perr;
  logic              w_aerr;
  logic [LEN_W-1:0]  w_hdr_len;

  // Gating with resetn keeps the router FIFO untouched while in reset.
  assign read_enb   = resetn & vld_out & sink_ready;

  assign byte_data  = data_out;
  assign byte_valid = r_cap_v;
  assign byte_sop   = r_cap_v && (r_state == HDR);
  assign byte_eop   = r_cap_v && (r_state == PAR);

  assign w_hdr_len  = hdr_len(data_out);
  assign w_par_cap  = r_cap_v && (r_state == PAR);
  assign w_perr     = (r_par_acc != data_out);
  assign w_aerr     = (r_addr != CHANNEL);

  // ---------------------------------------------------------------------------
  // Capture tracking and parser FSM; the FSM only moves on capture cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= HDR;
      r_cap_v   <= 1'b0;
      r_len     <= '0;
      r_rem     <= '0;
      r_addr    <= '0;
      r_par_acc <= '0;
    end else begin
      r_cap_v <= read_enb;
      if (r_cap_v) begin
        case (r_state)
          HDR: begin
            r_len     <= w_hdr_len;
            r_addr    <= hdr_addr(data_out);
            r_par_acc <= data_out;
            r_rem     <= w_hdr_len;
            // A zero-length packet goes straight to its parity byte.
            r_state   <= (w_hdr_len != '0) ? PAY : PAR;
          end
          PAY: begin
            r_par_acc <= r_par_acc ^ data_out;
            r_rem     <= r_rem - 6'd1;
            if (r_rem == 6'd1) begin
              r_state <= PAR;
            end
          end
          PAR: begin
            // Next byte is the following header; no idle cycle needed.
            r_state <= HDR;
          end
          default: begin
            r_state <= HDR;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion status, registered on the cycle after the parity capture.
  // Error flags are held until the next packet completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pkt_done   <= 1'b0;
      r_pkt_len    <= '0;
      r_parity_err <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_pkt_done <= w_par_cap;
      if (w_par_cap) begin
        r_pkt_len    <= r_len;
        r_parity_err <= w_perr;
        r_addr_err   <= w_aerr;
      end
    end
  end

  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign parity_err = r_parity_err;
  assign addr_err   = r_addr_err;
  assign dbg_state  = r_state;

  // ---------------------------------------------------------------------------
  // Statistics. Counters step on the same edge that raises pkt_done, so the
  // new counts are visible alongside the pulse.
  // ---------------------------------------------------------------------------
`ifdef RX_STATS_EN
  router_rx_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_pkt_cnt (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_inc   (w_par_cap),
    .o_cnt   (pkt_cnt)
  );

  router_rx_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_inc   (w_par_cap && (w_perr || w_aerr)),
    .o_cnt   (err_cnt)
  );
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_rx_sink.sv
// -----------------------------------------------------------------------------
// tb_router_rx_sink
// Bench for router_rx_sink with CHANNEL=1. A small array models the router
// FIFO (vld_out = non-empty, data_out registered one cycle after read_enb).
// Packets come from a table of headers with hand-computed expected results;
// a scoreboard queue holds every expected {sop, eop, byte} and a second queue
// holds the expected completion status per packet.
// -----------------------------------------------------------------------------
module tb_router_rx_sink;

  localparam logic [1:0] CHAN  = 2'd1;
  localparam int         CNT_W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic             vld_out;
  logic [7:0]       data_out = 8'h00;
  logic             sink_ready = 1'b0;
  logic             read_enb;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_sop;
  logic             byte_eop;
  logic             pkt_done;
  logic [5:0]       pkt_len;
  logic             parity_err;
  logic             addr_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       dbg_state;

  router_rx_sink #(
    .CHANNEL (CHAN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .sink_ready (sink_ready),
    .read_enb   (read_enb),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_sop   (byte_sop),
    .byte_eop   (byte_eop),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Router FIFO model
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem [0:4095];
  logic [11:0] wr_ptr = 12'd0;
  logic [11:0] rd_ptr = 12'd0;

  assign vld_out = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (read_enb) begin
      data_out <= fifo_mem[rd_ptr];
      rd_ptr   <= rd_ptr + 12'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0]       len;
    logic             perr;
    logic             aerr;
    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] ec;
  } res_t;

  typedef struct {
    logic [7:0] hdr;
    logic       flip;      // corrupt parity byte bit 0
    logic [5:0] exp_len;
    logic       exp_perr;
    logic       exp_aerr;
  } vec_t;

  logic [9:0] exp_q[$];   // {sop, eop, byte}
  res_t       res_q[$];

  int errors = 0;
  int checks = 0;
  int bytes_seen = 0;
  int done_seen = 0;
  int low_run = 0;
  logic prev_done = 1'b0;
  int m_pc = 0;
  int m_ec = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_byte(input logic [7:0] b, input logic sop, input logic eop);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 12'd1;
    exp_q.push_back({sop, eop, b});
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic flip,
                          input logic [5:0] exp_len, input logic exp_perr,
                          input logic exp_aerr);
    logic [7:0] par;
    logic [7:0] b;
    int n;
    res_t r;
    n   = int'(hdr[7:2]);
    par = hdr;
    push_byte(hdr, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      b   = 8'($urandom_range(0, 255));
      par = par ^ b;
      push_byte(b, 1'b0, 1'b0);
    end
    par = par ^ {7'd0, flip};
    push_byte(par, 1'b0, 1'b1);
`ifdef RX_STATS_EN
    m_pc++;
    if (exp_perr || exp_aerr) m_ec++;
`endif
    r.len  = exp_len;
    r.perr = exp_perr;
    r.aerr = exp_aerr;
    r.pc   = CNT_W'(m_pc);
    r.ec   = CNT_W'(m_ec);
    res_q.push_back(r);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_q.size() != 0 || res_q.size() != 0)) begin
      @(posedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d bytes and %0d packets outstanding",
               name, exp_q.size(), res_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [9:0] e;
    res_t r;
    if (resetn) begin
      if (byte_valid) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {22'd0, byte_sop, byte_eop, byte_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte", {22'd0, byte_sop, byte_eop, byte_data}, {22'd0, e});
        end
      end
      if (!sink_ready) begin
        check("read_enb_while_not_ready", {31'd0, read_enb}, 32'd0);
        low_run++;
        if (low_run >= 2) check("valid_after_ready_fall", {31'd0, byte_valid}, 32'd0);
      end else begin
        low_run = 0;
        if (vld_out) check("read_enb_when_ready", {31'd0, read_enb}, 32'd1);
      end
      if (pkt_done) begin
        done_seen++;
        check("pkt_done_width", {31'd0, prev_done}, 32'd0);
        if (res_q.size() == 0) begin
          check("unexpected_pkt_done", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check("pkt_len",    {26'd0, pkt_len},    {26'd0, r.len});
          check("parity_err", {31'd0, parity_err}, {31'd0, r.perr});
          check("addr_err",   {31'd0, addr_err},   {31'd0, r.aerr});
          check("pkt_cnt",    {16'd0, pkt_cnt},    {16'd0, r.pc});
          check("err_cnt",    {16'd0, err_cnt},    {16'd0, r.ec});
        end
      end
      prev_done = pkt_done;
    end else begin
      prev_done = 1'b0;
      low_run   = 0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_enb"},   {31'd0, read_enb},   32'd0);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_pkt_done"},   {31'd0, pkt_done},   32'd0);
    check({tag, "_pkt_len"},    {26'd0, pkt_len},    32'd0);
    check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    check({tag, "_addr_err"},   {31'd0, addr_err},   32'd0);
    check({tag, "_pkt_cnt"},    {16'd0, pkt_cnt},    32'd0);
    check({tag, "_err_cnt"},    {16'd0, err_cnt},    32'd0);
    check({tag, "_state"},      {30'd0, dbg_state},  32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs [8];

  initial begin
    int base;
    int dn;
    int k;

    // hdr, flip, len, perr, aerr
    vecs[0] = '{8'h39, 1'b0, 6'd14, 1'b0, 1'b0};  // len 14 addr 01
    vecs[1] = '{8'h39, 1'b1, 6'd14, 1'b1, 1'b0};  // bad parity
    vecs[2] = '{8'h3A, 1'b0, 6'd14, 1'b0, 1'b1};  // addr 10
    vecs[3] = '{8'h01, 1'b0, 6'd0,  1'b0, 1'b0};  // len 0, parity 0x01
    vecs[4] = '{8'h39, 1'b0, 6'd14, 1'b0, 1'b0};  // back-to-back after len 0
    vecs[5] = '{8'h05, 1'b0, 6'd1,  1'b0, 1'b0};  // len 1
    vecs[6] = '{8'hFD, 1'b0, 6'd63, 1'b0, 1'b0};  // maximum length
    vecs[7] = '{8'h02, 1'b1, 6'd0,  1'b1, 1'b1};  // both errors, counted once

    // Reset: a waiting byte must not be read while resetn is low.
    resetn = 1'b0;
    fifo_mem[wr_ptr] = 8'hA5;
    wr_ptr = wr_ptr + 12'd1;
    sink_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    wr_ptr = rd_ptr;  // drop the probe byte
    sink_ready = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Table vectors, all queued at once so packets run back-to-back.
    sink_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      push_pkt(vecs[v].hdr, vecs[v].flip, vecs[v].exp_len,
               vecs[v].exp_perr, vecs[v].exp_aerr);
    end
    wait_drain("table_drain", 1000);
    check("held_parity_err", {31'd0, parity_err}, 32'd1);
    check("held_addr_err",   {31'd0, addr_err},   32'd1);

    // Backpressure: sink_ready 3 cycles high / 3 cycles low.
    sink_ready = 1'b0;
    @(posedge clk);
    #1;
    push_pkt(8'h39, 1'b0, 6'd14, 1'b0, 1'b0);
    k = 0;
    while (k < 300 && (exp_q.size() != 0 || res_q.size() != 0)) begin
      sink_ready = ((k / 3) % 2) == 0;
      @(posedge clk);
      #1;
      k++;
    end
    sink_ready = 1'b1;
    wait_drain("backpressure_drain", 100);

    // Reset after the header and 5 payload bytes.
    base = bytes_seen;
    push_pkt(8'h39, 1'b0, 6'd14, 1'b0, 1'b0);
    k = 0;
    while (k < 100 && bytes_seen < base + 6) begin
      @(negedge clk);
      k++;
    end
    check("mid_pkt_bytes_reached", 32'(bytes_seen - base), 32'd6);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    res_q.delete();
    m_pc = 0;
    m_ec = 0;
    dn = done_seen;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    wr_ptr = rd_ptr;  // router flushes its FIFO too
    #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_seen - dn), 32'd0);

    // Fresh packet after reset.
    push_pkt(8'h39, 1'b0, 6'd14, 1'b0, 1'b0);
    wait_drain("post_reset_drain", 100);

    check("total_pkt_done", 32'(done_seen), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
